vending_machine_param: RTL and testbench

//   Parametrised vending controller. Accumulates coin credit, dispenses one item at PRICE,

---
 rtl/vending_machine_param.sv | 121 ++++++++++++
 tb/tb_vending_machine_param.sv | 126 ++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: coin credit, single-item vend, UNIT-step change/refund.
// Optional stock counter with sold_out/restock is enabled by defining VM_STOCK_EN.
module vending_machine_param #(
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 15,
  parameter int COIN_LO_VAL = 5,
  parameter int COIN_HI_VAL = 10,
  parameter int UNIT        = 5,
  parameter int STOCK_INIT  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_lo,
  input  logic                coin_hi,
  input  logic                cancel,
`ifdef VM_STOCK_EN
  input  logic                restock,
  output logic                sold_out,
`endif
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_REFUND} state_t;

  localparam logic [CREDIT_W:0]   LO_V    = (CREDIT_W+1)'(COIN_LO_VAL);
  localparam logic [CREDIT_W:0]   HI_V    = (CREDIT_W+1)'(COIN_HI_VAL);
  localparam logic [CREDIT_W:0]   PRICE_V = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(UNIT);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic                reject_reg, reject_next;
  logic [CREDIT_W:0]   coin_sum;
  logic                coins_blocked;

`ifdef VM_STOCK_EN
  localparam int STOCK_W = $clog2(STOCK_INIT + 1);
  logic [STOCK_W-1:0] stock_reg;

  // restock wins over a decrement on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stock_reg <= STOCK_W'(STOCK_INIT);
    else if (restock)
      stock_reg <= STOCK_W'(STOCK_INIT);
    else if (state_reg == S_VEND && stock_reg != '0)
      stock_reg <= stock_reg - 1'b1;
  end

  assign coins_blocked = (stock_reg == '0);
  assign sold_out      = coins_blocked;
`else
  localparam int unused_stock_init = STOCK_INIT;
  assign coins_blocked = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      credit_reg <= '0;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      reject_reg <= reject_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    reject_next = 1'b0;
    // coin_hi outranks coin_lo when both arrive together
    coin_sum    = {1'b0, credit_reg} + (coin_hi ? HI_V : LO_V);
    case (state_reg)
      S_IDLE, S_COLLECT: begin
        if (cancel && state_reg == S_COLLECT) begin
          state_next  = S_REFUND;
          reject_next = coin_hi | coin_lo;
        end else if (coin_hi || coin_lo) begin
          if (coin_hi && coin_lo)
            reject_next = 1'b1;
          if ((state_reg == S_IDLE && coins_blocked) || coin_sum[CREDIT_W]) begin
            reject_next = 1'b1;
          end else begin
            credit_next = coin_sum[CREDIT_W-1:0];
            state_next  = (coin_sum >= PRICE_V) ? S_VEND : S_COLLECT;
          end
        end
      end
      S_VEND: begin
        credit_next = credit_reg - PRICE_C;
        state_next  = (credit_reg != PRICE_C) ? S_REFUND : S_IDLE;
        reject_next = coin_hi | coin_lo;
      end
      S_REFUND: begin
        credit_next = credit_reg - UNIT_C;
        state_next  = (credit_reg == UNIT_C) ? S_IDLE : S_REFUND;
        reject_next = coin_hi | coin_lo;
      end
      default: begin
        state_next  = S_IDLE;
        credit_next = '0;
      end
    endcase
  end

  always_comb begin
    dispense     = (state_reg == S_VEND);
    change_pulse = (state_reg == S_REFUND);
    busy         = (state_reg == S_VEND) || (state_reg == S_REFUND);
    coin_reject  = reject_reg;
    credit       = credit_reg;
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: default instance plus a CREDIT_W=4 / STOCK_INIT=1 one.
// Stock tests run only when VM_STOCK_EN is defined.
module tb_vending_machine_param;

  logic       clk, rst_n, coin_lo, coin_hi, cancel, restock;
  logic       dispense, change_pulse, coin_reject, busy;
  logic [7:0] credit;
  logic       d2_dispense, d2_change_pulse, d2_coin_reject, d2_busy;
  logic [3:0] d2_credit;
`ifdef VM_STOCK_EN
  logic       sold_out, d2_sold_out;
`endif
  int checks = 0;
  int errors = 0;

  vending_machine_param dut (
    .clk(clk), .rst_n(rst_n), .coin_lo(coin_lo), .coin_hi(coin_hi), .cancel(cancel),
`ifdef VM_STOCK_EN
    .restock(restock), .sold_out(sold_out),
`endif
    .dispense(dispense), .change_pulse(change_pulse), .coin_reject(coin_reject),
    .busy(busy), .credit(credit)
  );

  vending_machine_param #(.CREDIT_W(4), .PRICE(15), .STOCK_INIT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .coin_lo(coin_lo), .coin_hi(coin_hi), .cancel(cancel),
`ifdef VM_STOCK_EN
    .restock(restock), .sold_out(d2_sold_out),
`endif
    .dispense(d2_dispense), .change_pulse(d2_change_pulse), .coin_reject(d2_coin_reject),
    .busy(d2_busy), .credit(d2_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one transaction: drive inputs, take one rising edge, sample 1 time unit later
  task automatic step(input logic hi, input logic lo, input logic can, input logic rs);
    coin_hi = hi; coin_lo = lo; cancel = can; restock = rs;
    @(posedge clk);
    #1;
    coin_hi = 1'b0; coin_lo = 1'b0; cancel = 1'b0; restock = 1'b0;
    $display("t=%0t hi=%b lo=%b cancel=%b restock=%b | credit=%0d disp=%b chg=%b rej=%b busy=%b | credit2=%0d rej2=%b",
             $time, hi, lo, can, rs, credit, dispense, change_pulse, coin_reject, busy,
             d2_credit, d2_coin_reject);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_credit", credit, 0);
    chk("rst_outs", {dispense, change_pulse, coin_reject, busy}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; coin_lo = 1'b0; coin_hi = 1'b0; cancel = 1'b0; restock = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: hi, hi -> 10, 20, vend, one change pulse
    step(1, 0, 0, 0); chk("t1_credit10", credit, 10); chk("t1_nodisp", dispense, 0);
    step(1, 0, 0, 0); chk("t1_credit20", credit, 20); chk("t1_disp", dispense, 1);
    chk("t1_busy", busy, 1);
    step(0, 0, 0, 0); chk("t1_disp_off", dispense, 0); chk("t1_chg", change_pulse, 1);
    chk("t1_credit5", credit, 5);
    step(0, 0, 0, 0); chk("t1_idle_chg", change_pulse, 0); chk("t1_credit0", credit, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: lo x3 -> exact price, no change; coin during VEND refused
    step(0, 1, 0, 0); chk("t2_credit5", credit, 5);
    step(0, 1, 0, 0); chk("t2_credit10", credit, 10);
    step(0, 1, 0, 0); chk("t2_disp", dispense, 1); chk("t2_busy", busy, 1);
    step(0, 1, 0, 0); chk("t2_after_vend", {dispense, change_pulse, busy}, 0);
    chk("t2_credit0", credit, 0); chk("t2_vend_coin_rej", coin_reject, 1);
    step(0, 0, 1, 0); chk("t2_idle_cancel", {change_pulse, busy, coin_reject}, 0);

    // 3: hi+lo same edge -> lo refused; then hi -> vend with 5 change
    step(1, 1, 0, 0); chk("t3_credit10", credit, 10); chk("t3_rej", coin_reject, 1);
    step(1, 0, 0, 0); chk("t3_credit20", credit, 20); chk("t3_rej_off", coin_reject, 0);
    chk("t3_disp", dispense, 1);
    step(0, 0, 0, 0); chk("t3_chg", change_pulse, 1);
    step(0, 0, 0, 0); chk("t3_idle", {busy, credit}, 0);

    // 4: hi, cancel+lo -> refusal, two change pulses, no dispense
    step(1, 0, 0, 0); chk("t4_credit10", credit, 10);
    step(0, 1, 1, 0); chk("t4_rej", coin_reject, 1); chk("t4_chg1", change_pulse, 1);
    chk("t4_credit_hold", credit, 10); chk("t4_nodisp", dispense, 0);
    step(0, 0, 0, 0); chk("t4_chg2", change_pulse, 1); chk("t4_credit5", credit, 5);
    chk("t4_rej_off", coin_reject, 0);
    step(0, 0, 0, 0); chk("t4_done", {change_pulse, busy, dispense}, 0);
    chk("t4_credit0", credit, 0);

    // 5: narrow instance, second hi would overflow 4-bit credit
    do_reset();
    step(1, 0, 0, 0); chk("t5_credit10", d2_credit, 10); chk("t5_rej0", d2_coin_reject, 0);
    step(1, 0, 0, 0); chk("t5_rej", d2_coin_reject, 1); chk("t5_credit_hold", d2_credit, 10);
    chk("t5_nodisp", d2_dispense, 0);
    step(0, 0, 1, 0); chk("t5_refund", d2_change_pulse, 1);

`ifdef VM_STOCK_EN
    // 6: single-item stock, sold out after one vend, restock reopens
    do_reset();
    chk("t6_rst_sold", d2_sold_out, 0);
    step(1, 0, 0, 0); chk("t6_credit10", d2_credit, 10);
    step(0, 1, 0, 0); chk("t6_disp", d2_dispense, 1);
    step(0, 0, 0, 0); chk("t6_sold", d2_sold_out, 1); chk("t6_credit0", d2_credit, 0);
    step(0, 1, 0, 0); chk("t6_rej", d2_coin_reject, 1); chk("t6_credit_hold", d2_credit, 0);
    step(0, 0, 0, 1); chk("t6_restock", d2_sold_out, 0);
    step(0, 1, 0, 0); chk("t6_accept", d2_credit, 5); chk("t6_rej_off", d2_coin_reject, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
